arrow_launch_scheduler: RTL and testbench

- Plays a step chart by sequencing the launch inputs of the per-lane arrow_movement instances.
- Fetches chart entries one at a time from an external synchronous ROM.
- For each entry, waits the specified number of video frames, then pulses launch on the selected lanes.
- Sits between the chart ROM / game-control logic and the lane datapaths; reports progress to the HUD/score logic.

---
 rtl/arrow_launch_scheduler.sv | 117 +++++++++++
 tb/tb_arrow_launch_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_launch_scheduler.sv
// Step-chart sequencer: fetches {mask, delay} entries from a synchronous ROM,
// counts video frames for each delay, then pulses launch on the selected lanes.
module arrow_launch_scheduler #(
   parameter int LANES   = 4,
   parameter int ADDR_W  = 8,
   parameter int DELAY_W = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       frame_i,
   input  logic                       start_i,
   input  logic                       pause_i,
   output logic                       chart_rd_o,
   output logic [ADDR_W-1:0]          chart_addr_o,
   input  logic [LANES+DELAY_W-1:0]   chart_data_i,
   output logic [LANES-1:0]           launch_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [ADDR_W-1:0]          step_count_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DELAY,
      S_FIRE,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [LANES-1:0]     mask_q, mask_d;
   logic [DELAY_W-1:0]   delay_q, delay_d;
   logic [ADDR_W-1:0]    step_q, step_d;

   logic [LANES-1:0]     rom_mask;
   logic [DELAY_W-1:0]   rom_delay;

   assign rom_mask  = chart_data_i[LANES+DELAY_W-1:DELAY_W];
   assign rom_delay = chart_data_i[DELAY_W-1:0];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      mask_d  = mask_q;
      delay_d = delay_q;
      step_d  = step_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               addr_d  = '0;
               step_d  = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            // ROM data is valid only in this cycle, so decide on it directly.
            mask_d  = rom_mask;
            delay_d = rom_delay;
            if (rom_mask == '0 && rom_delay == '0) begin
               state_d = S_DONE;
            end else if (rom_delay == '0) begin
               state_d = S_FIRE;
            end else begin
               state_d = S_DELAY;
            end
         end
         S_DELAY: begin
            if (frame_i && !pause_i) begin
               delay_d = delay_q - DELAY_W'(1);
               if (delay_q == DELAY_W'(1)) begin
                  state_d = S_FIRE;
               end
            end
         end
         S_FIRE: begin
            if (mask_q != '0 && step_q != '1) begin
               step_d = step_q + ADDR_W'(1);
            end
            // The last ROM slot ends the chart rather than wrapping to 0.
            if (addr_q == '1) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         mask_q  <= '0;
         delay_q <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         mask_q  <= mask_d;
         delay_q <= delay_d;
         step_q  <= step_d;
      end
   end

   assign chart_rd_o   = (state_q == S_FETCH);
   assign chart_addr_o = addr_q;
   assign launch_o     = (state_q == S_FIRE) ? mask_q : '0;
   assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o       = (state_q == S_DONE);
   assign step_count_o = step_q;

endmodule

// File: tb/tb_arrow_launch_scheduler.sv
// Directed bench for arrow_launch_scheduler: a table of single-entry charts
// plus hand-written multi-cycle sequences and a small-address instance.
module tb_arrow_launch_scheduler;

   logic        clk;
   logic        reset_i;
   logic        frame_i, start_i, pause_i;
   logic        chart_rd_o;
   logic [7:0]  chart_addr_o;
   logic [11:0] chart_data_i;
   logic [3:0]  launch_o;
   logic        busy_o, done_o;
   logic [7:0]  step_count_o;

   logic        start2;
   logic        rd2;
   logic [1:0]  addr2;
   logic [11:0] data2;
   logic [3:0]  launch2;
   logic        busy2, done2;
   logic [1:0]  step2;

   logic [11:0] rom  [0:255];
   logic [11:0] rom2 [0:3];

   int n_chk, n_fail;
   int n_launch, l_cyc, n_rd, rd1, busy1, step1, zero_rs;
   logic [3:0] l_val;

   typedef struct {
      logic [3:0] mask;
      int         dly;
      int         foff;
      int         ps;
      int         pe;
      int         exp_cyc;
      int         exp_steps;
   } vec_t;

   vec_t vecs [8];

   arrow_launch_scheduler #(.LANES(4), .ADDR_W(8), .DELAY_W(8)) dut (
      .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .start_i(start_i),
      .pause_i(pause_i), .chart_rd_o(chart_rd_o), .chart_addr_o(chart_addr_o),
      .chart_data_i(chart_data_i), .launch_o(launch_o), .busy_o(busy_o),
      .done_o(done_o), .step_count_o(step_count_o)
   );

   arrow_launch_scheduler #(.LANES(4), .ADDR_W(2), .DELAY_W(8)) dut2 (
      .clk_i(clk), .reset_i(reset_i), .frame_i(1'b0), .start_i(start2),
      .pause_i(1'b0), .chart_rd_o(rd2), .chart_addr_o(addr2),
      .chart_data_i(data2), .launch_o(launch2), .busy_o(busy2),
      .done_o(done2), .step_count_o(step2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM models: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (chart_rd_o) chart_data_i <= rom[chart_addr_o];
      if (rd2)        data2        <= rom2[addr2];
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
   endtask

   task automatic clear_rom();
      for (int a = 0; a < 256; a++) rom[a] = '0;
   endtask

   // Cycle 0 carries start_i; observation i reflects the DUT state in cycle i.
   task automatic run_chart(input int ncyc, input int foff, input int ps, input int pe,
                            input int st2, input int rs);
      n_launch = 0; l_cyc = -1; l_val = '0; n_rd = 0;
      rd1 = 0; busy1 = 0; step1 = -1; zero_rs = 0;
      start_i = 1'b1;
      frame_i = (foff == 0);
      pause_i = (ps <= 0 && pe >= 0);
      reset_i = (rs == 0);
      for (int i = 1; i <= ncyc; i++) begin
         tick();
         if (chart_rd_o) n_rd++;
         if (i == 1) begin
            rd1   = (chart_rd_o && chart_addr_o == 8'd0) ? 1 : 0;
            busy1 = busy_o;
            step1 = step_count_o;
         end
         if (i == rs + 1)
            zero_rs = (launch_o == 4'd0 && !chart_rd_o && !busy_o && !done_o &&
                       step_count_o == 8'd0) ? 1 : 0;
         if (launch_o != 4'd0) begin
            n_launch++;
            if (l_cyc < 0) begin
               l_cyc = i;
               l_val = launch_o;
            end
         end
         start_i = (i == st2);
         frame_i = (foff >= 0) && (i % 10 == foff);
         pause_i = (i >= ps && i <= pe);
         reset_i = (i == rs);
      end
      start_i = 1'b0; frame_i = 1'b0; pause_i = 1'b0; reset_i = 1'b0;
   endtask

   initial begin
      int lc [8];
      logic [3:0] lv [8];
      int n2, r2;
      n_chk = 0; n_fail = 0;
      reset_i = 1'b0; frame_i = 1'b0; start_i = 1'b0; pause_i = 1'b0; start2 = 1'b0;
      chart_data_i = '0; data2 = '0;
      clear_rom();

      // mask, delay, frame phase, pause window, launch cycle, final step count
      vecs[0] = '{4'b0101, 0,  5, -1, -1,  3, 1};
      vecs[1] = '{4'b0001, 3,  5, -1, -1, 26, 1};
      vecs[2] = '{4'b0001, 3,  5, 14, 16, 36, 1};
      vecs[3] = '{4'b1111, 1,  5, -1, -1,  6, 1};
      vecs[4] = '{4'b0000, 2,  5, -1, -1, -1, 0};
      vecs[5] = '{4'b1010, 0,  5,  0, 99,  3, 1};
      vecs[6] = '{4'b0010, 2,  2, -1, -1, 23, 1};
      vecs[7] = '{4'b0100, 1,  3, -1, -1,  4, 1};

      do_reset();
      chk("rst_launch", launch_o, 0);
      chk("rst_rd", chart_rd_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_step", step_count_o, 0);

      for (int k = 0; k < 8; k++) begin
         do_reset();
         clear_rom();
         rom[0] = {vecs[k].mask, 8'(vecs[k].dly)};
         run_chart(50, vecs[k].foff, vecs[k].ps, vecs[k].pe, -1, -1);
         chk($sformatf("v%0d_rd_addr0", k), rd1, 1);
         chk($sformatf("v%0d_busy", k), busy1, 1);
         chk($sformatf("v%0d_reads", k), n_rd, 2);
         chk($sformatf("v%0d_launches", k), n_launch, (vecs[k].exp_cyc >= 0) ? 1 : 0);
         chk($sformatf("v%0d_launch_cyc", k), l_cyc, vecs[k].exp_cyc);
         chk($sformatf("v%0d_launch_val", k), l_val,
             (vecs[k].exp_cyc >= 0) ? int'(vecs[k].mask) : 0);
         chk($sformatf("v%0d_steps", k), step_count_o, vecs[k].exp_steps);
         chk($sformatf("v%0d_done", k), done_o, 1);
         chk($sformatf("v%0d_idle_busy", k), busy_o, 0);
      end

      // Rest entry followed by a zero-delay entry and the end marker.
      do_reset();
      clear_rom();
      rom[0] = {4'b0000, 8'd2};
      rom[1] = {4'b1000, 8'd0};
      run_chart(40, 5, -1, -1, -1, -1);
      chk("rest_launches", n_launch, 1);
      chk("rest_launch_cyc", l_cyc, 19);
      chk("rest_launch_val", l_val, 8);
      chk("rest_reads", n_rd, 3);
      chk("rest_steps", step_count_o, 1);
      chk("rest_done", done_o, 1);

      // Reset while counting frames in DELAY.
      do_reset();
      clear_rom();
      rom[0] = {4'b0001, 8'd3};
      run_chart(40, 5, -1, -1, -1, 10);
      chk("rstmid_zero_outputs", zero_rs, 1);
      chk("rstmid_launches", n_launch, 0);
      chk("rstmid_reads", n_rd, 1);
      chk("rstmid_done", done_o, 0);

      // A second start while busy must not restart the chart.
      do_reset();
      clear_rom();
      rom[0] = {4'b0001, 8'd2};
      run_chart(40, 5, -1, -1, 4, -1);
      chk("busystart_launch_cyc", l_cyc, 16);
      chk("busystart_reads", n_rd, 2);
      chk("busystart_launches", n_launch, 1);
      chk("busystart_done", done_o, 1);
      chk("busystart_steps", step_count_o, 1);

      // Start from DONE replays from address 0 with the step count cleared.
      run_chart(40, 5, -1, -1, -1, -1);
      chk("replay_rd_addr0", rd1, 1);
      chk("replay_step_cleared", step1, 0);
      chk("replay_launch_cyc", l_cyc, 16);
      chk("replay_steps", step_count_o, 1);
      chk("replay_done", done_o, 1);

      // Two-bit address instance: four back-to-back entries, no end marker.
      rom2[0] = {4'b0001, 8'd0};
      rom2[1] = {4'b0010, 8'd0};
      rom2[2] = {4'b0100, 8'd0};
      rom2[3] = {4'b1000, 8'd0};
      do_reset();
      n2 = 0; r2 = 0;
      start2 = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         start2 = 1'b0;
         if (rd2) r2++;
         if (launch2 != 4'd0) begin
            if (n2 < 8) begin
               lc[n2] = i;
               lv[n2] = launch2;
            end
            n2++;
         end
      end
      chk("aend_launches", n2, 4);
      chk("aend_reads", r2, 4);
      if (n2 >= 4) begin
         for (int j = 0; j < 4; j++) begin
            chk($sformatf("aend_cyc%0d", j), lc[j], 3 + 3 * j);
            chk($sformatf("aend_val%0d", j), lv[j], 1 << j);
         end
      end
      chk("aend_steps_sat", step2, 3);
      chk("aend_done", done2, 1);
      chk("aend_busy", busy2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
